// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg : opcodes, redirect FSM states and sign-extension helpers for DLX.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package dlx_pkg;

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JR   = 6'h12;

  // Helpers extend to MAX_W; callers truncate to their datapath width.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] sext16(input logic [15:0] v);
    return {{(MAX_W-16){v[15]}}, v};
  endfunction

  function automatic logic [MAX_W-1:0] sext26(input logic [25:0] v);
    return {{(MAX_W-26){v[25]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/redirect_unit_if.sv
// -----------------------------------------------------------------------------
// redirect_unit_if : EX/ID operands in, redirect/stall controls and counters out.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface redirect_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_jr;
  logic [5:0]       ex_opcode;
  logic [WIDTH-1:0] ex_rs_val;
  logic [WIDTH-1:0] ex_rt_val;
  logic [WIDTH-1:0] ex_pc_plus4;
  logic [15:0]      ex_imm16;
  logic [25:0]      ex_off26;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;

  logic             branchCheck;
  logic             JumpCheck;
  logic             JRCheck;
  logic [WIDTH-1:0] redirect_pc;
  logic             pc_hold;
  logic             ifid_hold;
  logic             id_bubble;
  logic [CNT_W-1:0] redirect_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ex_branch, ex_jump, ex_jr, ex_opcode, ex_rs_val, ex_rt_val,
           ex_pc_plus4, ex_imm16, ex_off26, ex_mem_read, ex_rt,
           id_rs, id_rt, id_uses_rt,
    input  branchCheck, JumpCheck, JRCheck, redirect_pc,
           pc_hold, ifid_hold, id_bubble, redirect_count, stall_count
  );

  modport slave (
    input  ex_branch, ex_jump, ex_jr, ex_opcode, ex_rs_val, ex_rt_val,
           ex_pc_plus4, ex_imm16, ex_off26, ex_mem_read, ex_rt,
           id_rs, id_rt, id_uses_rt,
    output branchCheck, JumpCheck, JRCheck, redirect_pc,
           pc_hold, ifid_hold, id_bubble, redirect_count, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/redirect_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, async active-low clear.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         en,
  output      logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/redirect_unit.sv
// -----------------------------------------------------------------------------
// redirect_unit : EX-stage branch/jump resolution, load-use stall and perf counters.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module redirect_unit
  import dlx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHADOW = 2,
  parameter int CNT_W  = 16
) (
  input wire logic        clk,
  input wire logic        rst_n,
  redirect_unit_if.slave  bus
);
  localparam int SH_W = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);

  state_t          state, state_nxt;
  logic [SH_W-1:0] sh_cnt, sh_cnt_nxt;

  logic             active;
  logic             taken;
  logic             jr_chk, j_chk, b_chk, redirect;
  logic             load_use, stall;
  logic [WIDTH-1:0] tgt_j, tgt_b, tgt;

  always_comb begin
    taken = 1'b0;
    case (bus.ex_opcode)
      OP_BEQ:  taken = (bus.ex_rs_val == bus.ex_rt_val);
      OP_BNEZ: taken = (bus.ex_rs_val != '0);
      default: taken = 1'b0;
    endcase
  end

  // Gating with rst_n keeps every output low while reset is held.
  assign active   = rst_n && (state == ST_ACTIVE);
  assign jr_chk   = active & bus.ex_jr;
  assign j_chk    = active & bus.ex_jump & ~bus.ex_jr;
  assign b_chk    = active & bus.ex_branch & ~bus.ex_jump & ~bus.ex_jr & taken;
  assign redirect = jr_chk | j_chk | b_chk;

  assign tgt_j = bus.ex_pc_plus4 + WIDTH'(sext26(bus.ex_off26));
  assign tgt_b = bus.ex_pc_plus4 + WIDTH'(sext16(bus.ex_imm16));

  always_comb begin
    tgt = '0;
    if (jr_chk)      tgt = bus.ex_rs_val;
    else if (j_chk)  tgt = tgt_j;
    else if (b_chk)  tgt = tgt_b;
  end

  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  // A redirect flushes the ID instruction, so it never needs to stall.
  assign stall = load_use & ~redirect & active;

  assign bus.branchCheck = b_chk;
  assign bus.JumpCheck   = j_chk;
  assign bus.JRCheck     = jr_chk;
  assign bus.redirect_pc = tgt;
  assign bus.pc_hold     = stall;
  assign bus.ifid_hold   = stall;
  assign bus.id_bubble   = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_ACTIVE;
      sh_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sh_cnt <= sh_cnt_nxt;
    end
  end

  // Counter holds the masked cycles remaining, including the current one.
  always_comb begin
    state_nxt  = state;
    sh_cnt_nxt = sh_cnt;
    case (state)
      ST_ACTIVE: begin
        if (redirect && (SHADOW > 0)) begin
          state_nxt  = ST_SHADOW;
          sh_cnt_nxt = SH_W'(SHADOW);
        end
      end
      ST_SHADOW: begin
        if (sh_cnt <= SH_W'(1)) begin
          state_nxt  = ST_ACTIVE;
          sh_cnt_nxt = '0;
        end else begin
          sh_cnt_nxt = sh_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt  = ST_ACTIVE;
        sh_cnt_nxt = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect),
    .count (bus.redirect_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .count (bus.stall_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_redirect_unit : directed stimulus with a queue-based scoreboard and monitor.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_redirect_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  redirect_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();

  redirect_unit #(.WIDTH(32), .SHADOW(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        bc, jc, jrc;
    logic [31:0] pc;
    logic        hold;
    logic [15:0] rc, sc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // Monitor: outputs are combinational plus counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [69:0] got, want;
      e    = q.pop_front();
      got  = {bus.branchCheck, bus.JumpCheck, bus.JRCheck, bus.redirect_pc,
              bus.pc_hold, bus.ifid_hold, bus.id_bubble,
              bus.redirect_count, bus.stall_count};
      want = {e.bc, e.jc, e.jrc, e.pc, {3{e.hold}}, e.rc, e.sc};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got b/j/jr=%b%b%b pc=%h hold=%b%b%b rc=%h sc=%h, want b/j/jr=%b%b%b pc=%h hold=%b rc=%h sc=%h",
                 e.name, bus.branchCheck, bus.JumpCheck, bus.JRCheck, bus.redirect_pc,
                 bus.pc_hold, bus.ifid_hold, bus.id_bubble, bus.redirect_count,
                 bus.stall_count, e.bc, e.jc, e.jrc, e.pc, e.hold, e.rc, e.sc);
      end
    end
  end

  task automatic clr();
    bus.ex_branch   = 1'b0;
    bus.ex_jump     = 1'b0;
    bus.ex_jr       = 1'b0;
    bus.ex_opcode   = 6'h00;
    bus.ex_rs_val   = 32'h0;
    bus.ex_rt_val   = 32'h0;
    bus.ex_pc_plus4 = 32'h0;
    bus.ex_imm16    = 16'h0;
    bus.ex_off26    = 26'h0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = 5'd0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_uses_rt  = 1'b0;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic exp_cyc(input string nm, input logic bc, input logic jc,
                         input logic jrc, input logic [31:0] pc, input logic hold,
                         input logic [15:0] rc, input logic [15:0] sc);
    exp_t e;
    e.name = nm; e.bc = bc; e.jc = jc; e.jrc = jrc; e.pc = pc;
    e.hold = hold; e.rc = rc; e.sc = sc;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic load_use_rs();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd3; bus.id_rs = 5'd3;
  endtask

  initial begin
    clr();
    @(posedge clk); #1;

    bus.ex_jr = 1'b1; bus.ex_rs_val = 32'h1234;
    exp_cyc("reset_held", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
    rst_n = 1'b1; clr();
    exp_cyc("idle_after_reset", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);

    bus.ex_branch = 1'b1; bus.ex_opcode = 6'h04; bus.ex_rs_val = 32'd5;
    bus.ex_rt_val = 32'd5; bus.ex_pc_plus4 = 32'h100; bus.ex_imm16 = 16'hFFFC;
    exp_cyc("beq_taken",      1, 0, 0, 32'hFC, 0, 16'd0, 16'd0);
    exp_cyc("beq_shadow1",    0, 0, 0, 32'h0,  0, 16'd1, 16'd0);
    exp_cyc("beq_shadow2",    0, 0, 0, 32'h0,  0, 16'd1, 16'd0);
    exp_cyc("beq_redetect",   1, 0, 0, 32'hFC, 0, 16'd1, 16'd0);
    clr(); load_use_rs();
    exp_cyc("stall_in_shadow", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);
    clr();
    exp_cyc("shadow_idle",    0, 0, 0, 32'h0,  0, 16'd2, 16'd0);

    bus.ex_branch = 1'b1; bus.ex_opcode = 6'h05; bus.ex_rs_val = 32'd0;
    exp_cyc("bnez_zero",      0, 0, 0, 32'h0,  0, 16'd2, 16'd0);
    bus.ex_rs_val = 32'd7; bus.ex_imm16 = 16'h0010; bus.ex_pc_plus4 = 32'h200;
    exp_cyc("bnez_taken",     1, 0, 0, 32'h210, 0, 16'd2, 16'd0);
    clr();
    exp_cyc("sh_a1", 0, 0, 0, 32'h0, 0, 16'd3, 16'd0);
    exp_cyc("sh_a2", 0, 0, 0, 32'h0, 0, 16'd3, 16'd0);

    bus.ex_branch = 1'b1; bus.ex_opcode = 6'h05; bus.ex_rs_val = 32'd1;
    bus.ex_pc_plus4 = 32'hFFFF_FFF0; bus.ex_imm16 = 16'h0020;
    exp_cyc("branch_wrap",    1, 0, 0, 32'h10, 0, 16'd3, 16'd0);
    clr();
    exp_cyc("sh_b1", 0, 0, 0, 32'h0, 0, 16'd4, 16'd0);
    exp_cyc("sh_b2", 0, 0, 0, 32'h0, 0, 16'd4, 16'd0);

    bus.ex_jr = 1'b1; bus.ex_jump = 1'b1; bus.ex_branch = 1'b1;
    bus.ex_opcode = 6'h04; bus.ex_rs_val = 32'h4000; bus.ex_rt_val = 32'h4000;
    bus.ex_pc_plus4 = 32'h300; bus.ex_off26 = 26'h10;
    exp_cyc("jr_priority",    0, 0, 1, 32'h4000, 0, 16'd4, 16'd0);
    clr();
    exp_cyc("sh_c1", 0, 0, 0, 32'h0, 0, 16'd5, 16'd0);
    exp_cyc("sh_c2", 0, 0, 0, 32'h0, 0, 16'd5, 16'd0);

    bus.ex_jump = 1'b1; bus.ex_pc_plus4 = 32'h1000; bus.ex_off26 = 26'h3FF_FFF0;
    exp_cyc("jump_negative",  0, 1, 0, 32'hFF0, 0, 16'd5, 16'd0);
    clr();
    exp_cyc("sh_d1", 0, 0, 0, 32'h0, 0, 16'd6, 16'd0);
    exp_cyc("sh_d2", 0, 0, 0, 32'h0, 0, 16'd6, 16'd0);

    bus.ex_branch = 1'b1; bus.ex_opcode = 6'h08;
    exp_cyc("branch_bad_op",  0, 0, 0, 32'h0, 0, 16'd6, 16'd0);

    clr(); load_use_rs();
    exp_cyc("load_use_rs",    0, 0, 0, 32'h0, 1, 16'd6, 16'd0);
    clr();
    exp_cyc("after_stall1",   0, 0, 0, 32'h0, 0, 16'd6, 16'd1);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7;
    bus.id_rs = 5'd1; bus.id_uses_rt = 1'b1;
    exp_cyc("load_use_rt",    0, 0, 0, 32'h0, 1, 16'd6, 16'd1);
    bus.id_uses_rt = 1'b0;
    exp_cyc("rt_not_used",    0, 0, 0, 32'h0, 0, 16'd6, 16'd2);
    clr(); bus.ex_mem_read = 1'b1;
    exp_cyc("load_r0",        0, 0, 0, 32'h0, 0, 16'd6, 16'd2);
    load_use_rs(); bus.ex_jump = 1'b1; bus.ex_pc_plus4 = 32'h40; bus.ex_off26 = 26'h8;
    exp_cyc("load_use_jump",  0, 1, 0, 32'h48, 0, 16'd6, 16'd2);
    clr();
    exp_cyc("sh_e1", 0, 0, 0, 32'h0, 0, 16'd7, 16'd2);
    exp_cyc("sh_e2", 0, 0, 0, 32'h0, 0, 16'd7, 16'd2);

    load_use_rs();
    repeat (65541) @(posedge clk);
    #1;
    exp_cyc("stall_saturated", 0, 0, 0, 32'h0, 1, 16'd7, 16'hFFFF);
    clr();
    exp_cyc("sat_held",        0, 0, 0, 32'h0, 0, 16'd7, 16'hFFFF);

    bus.ex_jr = 1'b1; bus.ex_rs_val = 32'h88;
    exp_cyc("jr_before_reset", 0, 0, 1, 32'h88, 0, 16'd7, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    exp_cyc("reset_mid_shadow", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
    rst_n = 1'b1;
    exp_cyc("jr_after_release", 0, 0, 1, 32'h88, 0, 16'd0, 16'd0);
    exp_cyc("shadow_after_rel", 0, 0, 0, 32'h0,  0, 16'd1, 16'd0);

    @(posedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule

`default_nettype wire
